axil_cmd_master: RTL

AXI4-Lite initiator that turns single register commands (write or read) from a local valid/ready command port into AXI-Lite transactions. It returns each result on a response port. It drives the accelerator's register slave (control word at 0x000, control register at 0x010) from a sequencer, test harness or soft controller, and is the master counterpart of that slave. It handles one outstanding transaction at a time and watches for response stalls.

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axil_cmd_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding, register map.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [9:0] REG_CTRL    = 10'h000;
  localparam logic [9:0] REG_CONTROL = 10'h010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RRESP = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

  // True in the two states that wait on the slave's response channel.
  function automatic logic is_resp_wait(state_e s);
    return (s == ST_WRESP) || (s == ST_RRESP);
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one register command in, one AXI-Lite transaction out, one response back.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic                  stall,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CLOG_W = $clog2(STALL_LIMIT + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                write_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                aw_done_q, w_done_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                aw_hs, w_hs;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state decode; AW and W may complete in either order or together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = cmd_write ? ST_WADDR : ST_RADDR;
      ST_WADDR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WRESP;
      ST_WRESP: if (M_AXI_BVALID) state_d = ST_RSP;
      ST_RADDR: if (M_AXI_ARREADY) state_d = ST_RRESP;
      ST_RRESP: if (M_AXI_RVALID) state_d = ST_RSP;
      ST_RSP:   if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state and captured command/response.
  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_WADDR: begin
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
      end
      ST_WRESP: M_AXI_BREADY  = 1'b1;
      ST_RADDR: M_AXI_ARVALID = 1'b1;
      ST_RRESP: M_AXI_RREADY  = 1'b1;
      ST_RSP:   rsp_valid     = 1'b1;
      default:  busy          = 1'b0;
    endcase
    M_AXI_AWADDR = addr_q;
    M_AXI_ARADDR = addr_q;
    M_AXI_WDATA  = wdata_q;
    M_AXI_WSTRB  = wstrb_q;
    rsp_write    = write_q;
    rsp_rdata    = rdata_q;
    rsp_resp     = resp_q;
    stall        = is_resp_wait(state_q) && (stall_cnt_q == CNT_W'(STALL_LIMIT));
  end

  // Command capture, AW/W completion flags and response capture.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        ST_WADDR: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        ST_WRESP: begin
          if (M_AXI_BVALID) begin
            resp_q  <= M_AXI_BRESP;
            rdata_q <= '0;
          end
        end
        ST_RRESP: begin
          if (M_AXI_RVALID) begin
            resp_q  <= M_AXI_RRESP;
            rdata_q <= M_AXI_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating wait counter; zero outside the response-wait states and on exit from them.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      stall_cnt_q <= '0;
    end else if (is_resp_wait(state_q) && is_resp_wait(state_d)) begin
      if (stall_cnt_q != CNT_W'(STALL_LIMIT)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_q <= '0;
    end
  end

endmodule
